// File: rtl/vga_sync_receiver.sv
// Receive side of the VGA timing generator: samples HSync/VSync/pixel, locks onto
// the frame structure and regenerates column/line counters aligned to each pixel.
module vga_sync_receiver #(
    parameter int H_VISIBLE_AREA = 640,
    parameter int H_FRONT_PORCH  = 16,
    parameter int H_SYNC_PULSE   = 96,
    parameter int H_TOTAL        = 800,
    parameter int V_VISIBLE_AREA = 480,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_SYNC_PULSE   = 2,
    parameter int V_TOTAL        = 525
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VGA_HSync,
    input  logic       i_VGA_VSync,
    input  logic [8:0] i_VGA_Pixel,
    output logic [9:0] o_H_Counter,
    output logic [9:0] o_V_Counter,
    output logic [8:0] o_Pixel,
    output logic       o_Pixel_Valid,
    output logic       o_Frame_Start,
    output logic       o_Locked,
    output logic [7:0] o_Error_Count
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        H_ALIGN = 2'd1,
        V_ALIGN = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [9:0] HS_START = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE_AREA);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE_AREA);

    state_t     state;
    state_t     state_next;

    logic       hs_q, vs_q, hs_p, vs_p;
    logic [8:0] pix_q;
    logic [9:0] h_cnt, v_cnt;
    logic       rise_ok;

    logic       hs_fall, hs_rise, vs_fall, vs_rise;
    logic       h_at_start, h_at_end, h_at_zero;
    logic       exp_hs_low, exp_vs_low, sync_mismatch;

    logic       h_seed, v_seed, err_inc;
    logic [9:0] h_cur, v_cur;
    logic       locked_next, valid_next, frame_next;

    // Input stage: one register of the pins plus the previous sync levels for edges.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            hs_p  <= 1'b1;
            vs_p  <= 1'b1;
            pix_q <= '0;
        end else begin
            hs_q  <= i_VGA_HSync;
            vs_q  <= i_VGA_VSync;
            hs_p  <= hs_q;
            vs_p  <= vs_q;
            pix_q <= i_VGA_Pixel;
        end
    end

    // h_cnt/v_cnt are the free-running position of the sample currently in hs_q/pix_q.
    assign hs_fall       = hs_p & ~hs_q;
    assign hs_rise       = ~hs_p & hs_q;
    assign vs_fall       = vs_p & ~vs_q;
    assign vs_rise       = ~vs_p & vs_q;
    assign h_at_start    = (h_cnt == HS_START);
    assign h_at_end      = (h_cnt == HS_END);
    assign h_at_zero     = (h_cnt == 10'd0);
    assign exp_hs_low    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign exp_vs_low    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign sync_mismatch = (hs_q == exp_hs_low) || (vs_q == exp_vs_low);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH: begin
                if (hs_fall) state_next = H_ALIGN;
            end
            H_ALIGN: begin
                if (hs_fall && h_at_start && rise_ok) state_next = V_ALIGN;
            end
            V_ALIGN: begin
                if ((hs_fall && !h_at_start) || (hs_rise && !h_at_end)) begin
                    state_next = SEARCH;
                end else if (vs_fall && h_at_zero) begin
                    state_next = LOCKED;
                end else if ((vs_fall || vs_rise) && !h_at_zero) begin
                    state_next = SEARCH;
                end
            end
            LOCKED: begin
                if (sync_mismatch) state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
    end

    // Seeding replaces the free-running position of the current sample, so the
    // counters and outputs for that same sample already carry the aligned value.
    always_comb begin
        h_seed  = 1'b0;
        v_seed  = 1'b0;
        err_inc = 1'b0;
        case (state)
            SEARCH:  h_seed  = hs_fall;
            H_ALIGN: h_seed  = hs_fall && !(h_at_start && rise_ok);
            V_ALIGN: v_seed  = (state_next == LOCKED);
            LOCKED:  err_inc = (state_next == SEARCH);
            default: ;
        endcase
        h_cur       = h_seed ? HS_START : h_cnt;
        v_cur       = v_seed ? VS_START : v_cnt;
        locked_next = (state_next == LOCKED);
        valid_next  = locked_next && (h_cur < H_VIS) && (v_cur < V_VIS);
        frame_next  = locked_next && (h_cur == 10'd0) && (v_cur == 10'd0);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            rise_ok <= 1'b0;
        end else begin
            h_cnt <= (h_cur == H_LAST) ? 10'd0 : h_cur + 10'd1;
            if (h_cur == H_LAST) begin
                v_cnt <= (v_cur == V_LAST) ? 10'd0 : v_cur + 10'd1;
            end else begin
                v_cnt <= v_cur;
            end
            if (h_seed) begin
                rise_ok <= 1'b0;
            end else if (hs_rise) begin
                rise_ok <= h_at_end;
            end
        end
    end

    // o_Pixel_Valid qualifies o_Pixel/o_H_Counter/o_V_Counter each cycle; there is no backpressure.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_H_Counter   <= '0;
            o_V_Counter   <= '0;
            o_Pixel       <= '0;
            o_Pixel_Valid <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Locked      <= 1'b0;
            o_Error_Count <= '0;
        end else begin
            o_Locked      <= locked_next;
            o_Pixel_Valid <= valid_next;
            o_Frame_Start <= frame_next;
            o_Pixel       <= valid_next ? pix_q : 9'd0;
            if (state_next != SEARCH) begin
                o_H_Counter <= h_cur;
                o_V_Counter <= v_cur;
            end
            if (err_inc && (o_Error_Count != 8'hFF)) begin
                o_Error_Count <= o_Error_Count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a shrunken 16x8 frame: a source process
// pushes expected visible pixels, a negedge monitor pops and compares them.
module tb_vga_sync_receiver;

    localparam int HV  = 8;
    localparam int HFP = 2;
    localparam int HSP = 3;
    localparam int HT  = 16;
    localparam int VV  = 4;
    localparam int VFP = 1;
    localparam int VSP = 2;
    localparam int VT  = 8;
    localparam int HS_START   = HV + HFP;
    localparam int HS_END     = HS_START + HSP;
    localparam int VS_START   = VV + VFP;
    localparam int VS_END     = VS_START + VSP;
    localparam int FRAME      = HT * VT;
    localparam int LOCK_BOUND = FRAME + 2 * HT + 3;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic       i_VGA_HSync;
    logic       i_VGA_VSync;
    logic [8:0] i_VGA_Pixel;
    logic [9:0] o_H_Counter;
    logic [9:0] o_V_Counter;
    logic [8:0] o_Pixel;
    logic       o_Pixel_Valid;
    logic       o_Frame_Start;
    logic       o_Locked;
    logic [7:0] o_Error_Count;

    vga_sync_receiver #(
        .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_TOTAL(HT),
        .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_TOTAL(VT)
    ) dut (
        .i_Clk(i_Clk),
        .i_Reset(i_Reset),
        .i_VGA_HSync(i_VGA_HSync),
        .i_VGA_VSync(i_VGA_VSync),
        .i_VGA_Pixel(i_VGA_Pixel),
        .o_H_Counter(o_H_Counter),
        .o_V_Counter(o_V_Counter),
        .o_Pixel(o_Pixel),
        .o_Pixel_Valid(o_Pixel_Valid),
        .o_Frame_Start(o_Frame_Start),
        .o_Locked(o_Locked),
        .o_Error_Count(o_Error_Count)
    );

    // ---------------- clock / reset ----------------
    always #5 i_Clk = ~i_Clk;

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [28:0] exp_q[$];
    logic [28:0] mon_e;
    int total = 0;
    int bad   = 0;
    int valid_cnt, fs_cnt, last_fs;
    bit mon_en = 1'b0;

    // ---------------- source control ----------------
    int src_h = 0;
    int src_v = 0;
    int src_htotal = HT;
    int req_htotal = HT;
    int frames_to_push = 0;
    int glitch_cyc = 0;
    bit push_on = 1'b0;
    bit push_done = 1'b0;
    bit hs_glitch_arm = 1'b0;
    bit vs_glitch_every = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver: free-running VGA source ----------------
    initial begin : source
        logic [9:0] h10, v10;
        logic [8:0] pix;
        logic       hs, vs;
        i_VGA_HSync = 1'b1;
        i_VGA_VSync = 1'b1;
        i_VGA_Pixel = '0;
        forever begin
            @(posedge i_Clk);
            #1;
            if (src_h == 0 && src_v == 0) begin
                src_htotal = req_htotal;
                if (frames_to_push > 0) begin
                    push_on = 1'b1;
                    frames_to_push--;
                end else if (push_on) begin
                    push_on   = 1'b0;
                    push_done = 1'b1;
                end
            end
            h10 = 10'(src_h);
            v10 = 10'(src_v);
            hs  = !(src_h >= HS_START && src_h < HS_END);
            vs  = !(src_v >= VS_START && src_v < VS_END);
            if (hs_glitch_arm && src_v == 2 && src_h == HS_END) begin
                hs            = 1'b0;
                glitch_cyc    = cyc;
                hs_glitch_arm = 1'b0;
            end
            if (vs_glitch_every && src_v == 0 && src_h == 5) vs = 1'b0;
            if (src_h < HV && src_v < VV) pix = {h10[4:0], v10[3:0]};
            else                          pix = 9'($urandom_range(0, 511));
            i_VGA_HSync = hs;
            i_VGA_VSync = vs;
            i_VGA_Pixel = pix;
            if (push_on && src_h < HV && src_v < VV) exp_q.push_back({h10, v10, pix});
            src_h++;
            if (src_h >= src_htotal) begin
                src_h = 0;
                src_v = (src_v == VT - 1) ? 0 : src_v + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge i_Clk) begin
        if (mon_en) begin
            if (o_Pixel_Valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(o_Pixel_Valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_h_counter", 32'(o_H_Counter), 32'(mon_e[28:19]));
                    chk("sb_v_counter", 32'(o_V_Counter), 32'(mon_e[18:9]));
                    chk("sb_pixel", 32'(o_Pixel), 32'(mon_e[8:0]));
                    valid_cnt++;
                end
            end else begin
                chk("pixel_zero_when_invalid", 32'(o_Pixel), 32'd0);
            end
            if (o_Frame_Start) begin
                fs_cnt++;
                chk("frame_start_at_origin", 32'({o_H_Counter, o_V_Counter}), 32'd0);
                if (last_fs >= 0) chk("frame_start_period", cyc - last_fs, FRAME);
                last_fs = cyc;
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic check_zero();
        chk("rst_locked", 32'(o_Locked), 32'd0);
        chk("rst_valid", 32'(o_Pixel_Valid), 32'd0);
        chk("rst_frame_start", 32'(o_Frame_Start), 32'd0);
        chk("rst_h_counter", 32'(o_H_Counter), 32'd0);
        chk("rst_v_counter", 32'(o_V_Counter), 32'd0);
        chk("rst_pixel", 32'(o_Pixel), 32'd0);
        chk("rst_error_count", 32'(o_Error_Count), 32'd0);
    endtask

    task automatic pulse_reset();
        i_Reset = 1'b1;
        @(negedge i_Clk);
        i_Reset = 1'b0;
    endtask

    task automatic wait_lock(input string name);
        int n;
        n = 0;
        while (o_Locked !== 1'b1 && n < LOCK_BOUND) begin
            @(negedge i_Clk);
            n++;
        end
        chk(name, 32'(o_Locked), 32'd1);
    endtask

    task automatic wait_htotal(input int ht);
        int n;
        req_htotal = ht;
        n = 0;
        while (src_htotal != ht && n < 3 * FRAME) begin
            @(negedge i_Clk);
            n++;
        end
        chk("source_htotal_applied", src_htotal, ht);
    endtask

    task automatic run_checked_frames(input int n, input int exp_err);
        int k;
        last_fs   = -1;
        valid_cnt = 0;
        fs_cnt    = 0;
        push_done = 1'b0;
        mon_en    = 1'b1;
        frames_to_push = n;
        k = 0;
        while (!push_done && k < (n + 2) * FRAME) begin
            @(negedge i_Clk);
            k++;
        end
        mon_en = 1'b0;
        chk("push_window_done", 32'(push_done), 32'd1);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        chk("valid_per_window", valid_cnt, n * HV * VV);
        chk("frame_start_count", fs_cnt, n);
        chk("error_count", 32'(o_Error_Count), 32'(exp_err));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int k;
        bit saw_lock, wrapped;
        logic [7:0] prev_err;

        i_Reset = 1'b1;
        repeat (3) @(negedge i_Clk);
        check_zero();
        i_Reset = 1'b0;

        // Clean source: lock, then three fully scoreboarded frames.
        wait_lock("initial_lock");
        run_checked_frames(3, 0);

        // One extra HSync-low cycle on line 2 while locked.
        hs_glitch_arm = 1'b1;
        k = 0;
        while (o_Locked === 1'b1 && k < 3 * FRAME) begin
            @(negedge i_Clk);
            k++;
        end
        chk("hs_glitch_lock_drop", 32'(o_Locked), 32'd0);
        chk("hs_glitch_drop_delay", cyc - glitch_cyc, 2);
        chk("hs_glitch_valid_low", 32'(o_Pixel_Valid), 32'd0);
        chk("hs_glitch_error_count", 32'(o_Error_Count), 32'd1);
        wait_lock("relock_after_hs_glitch");
        run_checked_frames(1, 1);

        // Single-cycle reset mid-frame while locked.
        repeat (37) @(negedge i_Clk);
        chk("locked_before_reset", 32'(o_Locked), 32'd1);
        pulse_reset();
        check_zero();
        wait_lock("relock_after_reset");
        run_checked_frames(1, 0);

        // 17-pixel lines must never lock and never count errors.
        wait_htotal(HT + 1);
        pulse_reset();
        saw_lock = 1'b0;
        repeat (3 * (HT + 1) * VT) begin
            @(negedge i_Clk);
            if (o_Locked) saw_lock = 1'b1;
        end
        chk("no_lock_ht17", 32'(saw_lock), 32'd0);
        chk("no_error_ht17", 32'(o_Error_Count), 32'd0);
        wait_htotal(HT);
        pulse_reset();
        wait_lock("relock_ht16");

        // VSync glitch every frame: error count saturates without wrapping.
        prev_err = o_Error_Count;
        wrapped  = 1'b0;
        vs_glitch_every = 1'b1;
        repeat (262 * FRAME) begin
            @(negedge i_Clk);
            if (o_Error_Count < prev_err) wrapped = 1'b1;
            prev_err = o_Error_Count;
        end
        vs_glitch_every = 1'b0;
        chk("error_count_saturated", 32'(o_Error_Count), 32'd255);
        chk("error_count_no_wrap", 32'(wrapped), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
